// File: rtl/led_bist_sequencer.sv
// LED bank self-test sequencer.
// Steps the LEDs through all-on, a walking one and all-off, repeating the
// pattern LOOPS times. A programmable divider sets the step period, and the
// block emits a single-cycle step_tick rather than a derived clock. Every
// output comes straight from a flop.
module led_bist_sequencer #(
  parameter int STEP_DIV = 50_000_000,
  parameter int N_LED    = 8,
  parameter int LOOPS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       rate_sel,
  output logic [N_LED-1:0] led,
  output logic             busy,
  output logic             done,
  output logic             step_tick,
  output logic [1:0]       phase
);

  localparam int CNT_W  = $clog2(STEP_DIV);
  localparam int IDX_W  = $clog2(N_LED);
  localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_LED - 1);
  localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ALL_ON  = 2'd1,
    S_WALK    = 2'd2,
    S_ALL_OFF = 2'd3
  } state_t;

  // Terminal count for the selected rate. The divider counts 0..div_eff-1,
  // so the value held is div_eff-1. A shift that would reach zero is clamped
  // to a one-cycle step so the counter can never get stuck.
  function automatic logic [CNT_W-1:0] f_div_last(input logic [1:0] sel);
    int d;
    d = STEP_DIV >> (2 * int'(sel));
    if (d < 1) begin
      d = 1;
    end
    return CNT_W'(d - 1);
  endfunction

  // One-hot LED pattern for walk position idx.
  function automatic logic [N_LED-1:0] f_walk_led(input logic [IDX_W-1:0] idx);
    return N_LED'(1) << idx;
  endfunction

  // Registered state
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_last;
  logic [IDX_W-1:0]    r_idx;
  logic [LOOP_W-1:0]   r_loop;
  logic [N_LED-1:0]    r_led;
  logic                r_busy;
  logic                r_done;
  logic                r_tick;

  // Next-state values
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    w_last_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [LOOP_W-1:0]   w_loop_nxt;
  logic [N_LED-1:0]    w_led_nxt;
  logic                w_done_nxt;
  logic                w_tick_nxt;
  logic                w_step_end;

  // State and output register; every field returns to its idle value on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= '0;
      r_idx   <= '0;
      r_loop  <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_idx   <= w_idx_nxt;
      r_loop  <= w_loop_nxt;
      r_led   <= w_led_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  // Next-state logic. The divider, pattern and loop count advance together.
  // Abort takes priority over a step boundary in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_idx_nxt   = r_idx;
    w_loop_nxt  = r_loop;
    w_led_nxt   = r_led;
    w_done_nxt  = 1'b0;
    w_step_end  = (r_state != S_IDLE) && (r_cnt == r_last);

    if (r_state == S_IDLE) begin
      w_cnt_nxt = '0;
      if (start && !abort) begin
        // The rate is latched here and held for the whole run.
        w_state_nxt = S_ALL_ON;
        w_last_nxt  = f_div_last(rate_sel);
        w_idx_nxt   = '0;
        w_loop_nxt  = '0;
        w_led_nxt   = '1;
      end
    end else if (abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_loop_nxt  = '0;
      w_led_nxt   = '0;
    end else if (w_step_end) begin
      w_cnt_nxt = '0;
      case (r_state)
        S_ALL_ON: begin
          w_state_nxt = S_WALK;
          w_idx_nxt   = '0;
          w_led_nxt   = f_walk_led('0);
        end
        S_WALK: begin
          if (r_idx == IDX_LAST) begin
            w_state_nxt = S_ALL_OFF;
            w_idx_nxt   = '0;
            w_led_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
            w_led_nxt = f_walk_led(r_idx + IDX_W'(1));
          end
        end
        S_ALL_OFF: begin
          if (r_loop == LOOP_LAST) begin
            w_state_nxt = S_IDLE;
            w_loop_nxt  = '0;
            w_led_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_ALL_ON;
            w_loop_nxt  = r_loop + LOOP_W'(1);
            w_led_nxt   = '1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_led_nxt   = '0;
        end
      endcase
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    // step_tick is registered, so it is derived from the next counter value.
    w_tick_nxt = (w_state_nxt != S_IDLE) && (w_cnt_nxt == w_last_nxt);
  end

  assign led       = r_led;
  assign busy      = r_busy;
  assign done      = r_done;
  assign step_tick = r_tick;
  assign phase     = r_state;

endmodule

// File: tb/tb_led_bist_sequencer.sv
// Self-checking bench for led_bist_sequencer. A run is modelled as elapsed
// cycles since start; the expected outputs are computed from that count.
module tb_led_bist_sequencer;

  localparam int STEP_DIV = 64;
  localparam int N_LED    = 4;
  localparam int LOOPS    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [1:0]       rate_sel = 2'd0;
  logic [N_LED-1:0] led;
  logic             busy;
  logic             done;
  logic             step_tick;
  logic [1:0]       phase;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  int m_t      = 0;
  int m_div    = 1;

  led_bist_sequencer #(
    .STEP_DIV(STEP_DIV),
    .N_LED   (N_LED),
    .LOOPS   (LOOPS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .rate_sel (rate_sel),
    .led      (led),
    .busy     (busy),
    .done     (done),
    .step_tick(step_tick),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  function automatic int run_len(input int div);
    return LOOPS * (N_LED + 2) * div;
  endfunction

  // Advance the model across one rising edge given the inputs presented.
  task automatic model_edge(input bit s, input bit a, input logic [1:0] rs);
    m_done = 1'b0;
    if (!rst) begin
      m_active = 1'b0;
      m_t = 0;
    end else if (m_active) begin
      if (a) begin
        m_active = 1'b0;
      end else begin
        m_t++;
        if (m_t == run_len(m_div)) begin
          m_active = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (s && !a) begin
      m_active = 1'b1;
      m_t = 0;
      m_div = STEP_DIV >> (2 * int'(rs));
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int s;
    logic [N_LED-1:0] el;
    logic [1:0] ep;
    logic et;
    el = '0;
    ep = 2'd0;
    et = 1'b0;
    if (m_active) begin
      s = (m_t / m_div) % (N_LED + 2);
      if (s == 0) begin
        el = '1;
        ep = 2'd1;
      end else if (s <= N_LED) begin
        el = N_LED'(1) << (s - 1);
        ep = 2'd2;
      end else begin
        el = '0;
        ep = 2'd3;
      end
      et = ((m_t % m_div) == m_div - 1);
    end
    chk("led", 32'(led), 32'(el));
    chk("busy", 32'(busy), 32'(m_active));
    chk("done", 32'(done), 32'(m_done));
    chk("step_tick", 32'(step_tick), 32'(et));
    chk("phase", 32'(phase), 32'(ep));
  endtask

  // Present inputs, take one edge, then sample 1 ns later.
  task automatic cyc(input bit s, input bit a, input logic [1:0] rs);
    start = s;
    abort = a;
    rate_sel = rs;
    @(posedge clk);
    model_edge(s, a, rs);
    #1;
    check_outputs();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, rate_sel);
  endtask

  initial begin
    // Held in reset, then released: everything idle.
    repeat (3) cyc(1'b0, 1'b0, 2'd0);
    rst = 1'b1;
    idle(3);

    // Run at div 16; rate_sel dropped to 0 mid-run must not matter.
    cyc(1'b1, 1'b0, 2'd1);
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, 2'd1);
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, 2'd0);

    // Run at div 4 with start re-pulsed while busy.
    cyc(1'b1, 1'b0, 2'd2);
    for (int i = 0; i < 46; i++) cyc((i % 7) == 3, 1'b0, 2'd2);
    idle(10);

    // start together with abort in idle is rejected.
    cyc(1'b1, 1'b1, 2'd2);
    idle(3);

    // Abort on the step_tick of walk index 2 (t == 3*div + div-1 = 15).
    cyc(1'b1, 1'b0, 2'd2);
    for (int i = 0; i < 40 && !(m_active && m_t == 15); i++) cyc(1'b0, 1'b0, 2'd2);
    chk("abort_point_phase", 32'(phase), 32'd2);
    chk("abort_point_led", 32'(led), 32'b0100);
    chk("abort_point_tick", 32'(step_tick), 32'd1);
    cyc(1'b0, 1'b1, 2'd2);
    idle(2);
    cyc(1'b1, 1'b0, 2'd2);
    chk("restart_led", 32'(led), 32'hF);
    for (int i = 0; i < 200 && !m_done; i++) cyc(1'b0, 1'b0, 2'd2);
    chk("done_seen", 32'(done), 32'd1);

    // Start in the done cycle is accepted; run at the fastest rate.
    cyc(1'b1, 1'b0, 2'd3);
    chk("start_in_done_busy", 32'(busy), 32'd1);
    idle(20);

    // Asynchronous reset between edges during ALL_ON.
    cyc(1'b1, 1'b0, 2'd1);
    idle(5);
    chk("pre_reset_phase", 32'(phase), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_led", 32'(led), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_phase", 32'(phase), 32'd0);
    chk("async_rst_tick", 32'(step_tick), 32'd0);
    m_active = 1'b0;
    m_done = 1'b0;
    m_t = 0;
    idle(2);
    rst = 1'b1;
    idle(10);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 299) == 0, 2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
